// File: rtl/register_status_file_pkg.sv
// Shared definitions for the register status file: word, index and ROB tag
// ranges, null values and the commit payload.
package register_status_file_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned TAG_WIDTH = 4;
  localparam int unsigned BUSY_W    = 6;

  typedef logic [XLEN-1:0]      word_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [TAG_WIDTH-1:0] tag_t;
  typedef logic [BUSY_W-1:0]    busy_t;

  localparam tag_t     NULL_TAG       = TAG_WIDTH'(0);
  localparam word_t    ZERO_WORD      = XLEN'(0);
  localparam reg_idx_t ZERO_REG_INDEX = REG_IDX_W'(0);

  // Register-writing commit from the reorder-buffer head.
  typedef struct packed {
    reg_idx_t target;
    tag_t     tag;
    word_t    data;
  } commit_t;

endpackage : register_status_file_pkg

// File: rtl/register_status_file_read_port.sv
// rsf_read_port: combinational operand lookup for one source register.
// Applies the x0 rule, then the same-cycle commit bypass, then the stored
// tag/value.
//   rs_i              source register index
//   tag_lookup_i      stored rename tag of rs_i
//   value_lookup_i    stored architectural value of rs_i
//   commit_valid_i    a register-writing commit is present this cycle
//   commit_i          commit payload (target, tag, data)
//   src_tag_c_o       producer tag, NULL_TAG when the value is ready
//   src_value_c_o     operand value (meaningful only with NULL_TAG)
module rsf_read_port
  import register_status_file_pkg::*;
(
  input  logic     [REG_IDX_W-1:0] rs_i,
  input  logic     [TAG_WIDTH-1:0] tag_lookup_i,
  input  logic     [XLEN-1:0]      value_lookup_i,
  input  logic                     commit_valid_i,
  input  commit_t                  commit_i,
  output logic     [TAG_WIDTH-1:0] src_tag_c_o,
  output logic     [XLEN-1:0]      src_value_c_o
);

  logic bypass_hit_c;

  // The commit resolves this operand only if it is the newest producer.
  assign bypass_hit_c = commit_valid_i
                     && (commit_i.target == rs_i)
                     && (commit_i.tag == tag_lookup_i);

  always_comb begin
    src_tag_c_o   = tag_lookup_i;
    src_value_c_o = value_lookup_i;
    if (rs_i == ZERO_REG_INDEX) begin
      src_tag_c_o   = NULL_TAG;
      src_value_c_o = ZERO_WORD;
    end else if (bypass_hit_c) begin
      src_tag_c_o   = NULL_TAG;
      src_value_c_o = commit_i.data;
    end
  end

endmodule : rsf_read_port

// File: rtl/register_status_file.sv
// register_status_file: architectural register file plus rename-status
// table. Retires ROB commits into 32 registers, renames rd on issue,
// serves two zero-latency source operands and drops all renames on rollback.
//   clk, rst_n                   clock, async active-low reset
//   rollback_in                  flush: clear every rename tag
//   dec_issue_in/rd/tag          issue and rename of the destination register
//   dec_rs1_in, dec_rs2_in       source operand indices
//   dec_Qj/Qk_out                producer tags (NULL_TAG when value valid)
//   dec_Vj/Vk_out                operand values
//   commit_rf_signal_in/target/tag/data   ROB register commit
//   busy_count_out               registered count of renamed registers
module register_status_file
  import register_status_file_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rollback_in,
  input  logic                 dec_issue_in,
  input  logic [REG_IDX_W-1:0] dec_rd_in,
  input  logic [TAG_WIDTH-1:0] dec_tag_in,
  input  logic [REG_IDX_W-1:0] dec_rs1_in,
  input  logic [REG_IDX_W-1:0] dec_rs2_in,
  output logic [TAG_WIDTH-1:0] dec_Qj_out,
  output logic [TAG_WIDTH-1:0] dec_Qk_out,
  output logic [XLEN-1:0]      dec_Vj_out,
  output logic [XLEN-1:0]      dec_Vk_out,
  input  logic                 commit_rf_signal_in,
  input  logic [REG_IDX_W-1:0] commit_target_in,
  input  logic [TAG_WIDTH-1:0] commit_tag_in,
  input  logic [XLEN-1:0]      commit_data_in,
  output logic [BUSY_W-1:0]    busy_count_out
);

  word_t   value_q [REG_COUNT];
  word_t   value_d [REG_COUNT];
  tag_t    tag_q   [REG_COUNT];
  tag_t    tag_d   [REG_COUNT];
  busy_t   busy_q;
  busy_t   busy_d;

  commit_t commit_c;
  logic    commit_we_c;
  logic    issue_we_c;

  assign commit_c    = '{target: commit_target_in, tag: commit_tag_in, data: commit_data_in};
  assign commit_we_c = commit_rf_signal_in && (commit_target_in != ZERO_REG_INDEX);
  assign issue_we_c  = dec_issue_in && !rollback_in && (dec_rd_in != ZERO_REG_INDEX);

  // Storage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        value_q[i] <= ZERO_WORD;
        tag_q[i]   <= NULL_TAG;
      end
      busy_q <= '0;
    end else begin
      value_q <= value_d;
      tag_q   <= tag_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: commit first, then rollback or issue override the tag.
  always_comb begin
    value_d = value_q;
    tag_d   = tag_q;

    if (commit_we_c) begin
      value_d[commit_target_in] = commit_data_in;
      // A younger rename of the same register must survive this commit.
      if (tag_q[commit_target_in] == commit_tag_in) begin
        tag_d[commit_target_in] = NULL_TAG;
      end
    end

    if (rollback_in) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        tag_d[i] = NULL_TAG;
      end
    end else if (issue_we_c) begin
      tag_d[dec_rd_in] = dec_tag_in;
    end

    // x0 is hardwired; keep its storage pinned regardless of inputs.
    value_d[0] = ZERO_WORD;
    tag_d[0]   = NULL_TAG;
  end

  // Busy count from next-state tags so it tracks the register contents.
  always_comb begin
    busy_d = '0;
    for (int i = 1; i < int'(REG_COUNT); i++) begin
      if (tag_d[i] != NULL_TAG) begin
        busy_d = busy_d + BUSY_W'(1);
      end
    end
  end

  assign busy_count_out = busy_q;

  rsf_read_port u_read_rs1 (
    .rs_i           (dec_rs1_in),
    .tag_lookup_i   (tag_q[dec_rs1_in]),
    .value_lookup_i (value_q[dec_rs1_in]),
    .commit_valid_i (commit_rf_signal_in),
    .commit_i       (commit_c),
    .src_tag_c_o    (dec_Qj_out),
    .src_value_c_o  (dec_Vj_out)
  );

  rsf_read_port u_read_rs2 (
    .rs_i           (dec_rs2_in),
    .tag_lookup_i   (tag_q[dec_rs2_in]),
    .value_lookup_i (value_q[dec_rs2_in]),
    .commit_valid_i (commit_rf_signal_in),
    .commit_i       (commit_c),
    .src_tag_c_o    (dec_Qk_out),
    .src_value_c_o  (dec_Vk_out)
  );

endmodule : register_status_file

// File: doc/register_status_file.md
Name: register_status_file

Overview:
- Architectural register file plus rename-status table for the Tomasulo core.
- It is the receiving end of the reorder-buffer commit interface. It takes the register-writing commits (commit_rf signal, target, tag, data) and retires them into the 32 architectural registers. A commit clears a register's rename tag only when the committing tag is still the newest producer.
- It serves the decoder: source operands (value or producing tag) each cycle, and rd renaming on issue.
- On rollback it discards all rename tags and keeps the committed values.

Parameters:
- XLEN, 32, data word width.
- REG_COUNT, 32, number of architectural registers (index width log2 = 5).
- TAG_WIDTH, 4, reorder-buffer tag width; tag 0 is NULL_TAG (no producer).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rollback_in  in  1  pipeline flush; clear every rename tag
- dec_issue_in  in  1  decoder issues an instruction this cycle
- dec_rd_in  in  5  destination register of the issued instruction
- dec_tag_in  in  TAG_WIDTH  reorder-buffer tag allocated to the issued instruction
- dec_rs1_in  in  5  source register 1
- dec_rs2_in  in  5  source register 2
- dec_Qj_out  out  TAG_WIDTH  producer tag of rs1, NULL_TAG if the value is valid
- dec_Qk_out  out  TAG_WIDTH  producer tag of rs2, NULL_TAG if the value is valid
- dec_Vj_out  out  XLEN  value of rs1 (meaningful only when Qj is NULL_TAG)
- dec_Vk_out  out  XLEN  value of rs2 (meaningful only when Qk is NULL_TAG)
- commit_rf_signal_in  in  1  reorder-buffer head commits a register write
- commit_target_in  in  5  committed destination register
- commit_tag_in  in  TAG_WIDTH  tag of the committing entry
- commit_data_in  in  XLEN  committed result
- busy_count_out  out  6  number of registers with a non-null tag (registered)

Behaviour:
- Storage: value[REG_COUNT] (XLEN wide) and tag[REG_COUNT] (TAG_WIDTH wide).
- Reset (rst_n low, asynchronous):
  - All values are 0 and all tags are NULL_TAG.
  - busy_count_out = 0.
  - Read outputs therefore show Q = 0 and V = 0 immediately.
- Read ports are combinational and have zero latency. For each source rs:
  - rs == 0: Q = NULL_TAG, V = 0, always.
  - Commit bypass: if commit_rf_signal_in is high, commit_target_in == rs, and tag[rs] == commit_tag_in, then Q = NULL_TAG and V = commit_data_in.
  - Otherwise Q = tag[rs] and V = value[rs].
  - A same-cycle issue never affects reads. An instruction with rs == rd sees the state before its own rename.
- Commit, at posedge, when commit_rf_signal_in is high and commit_target_in != 0:
  - value[target] <= commit_data_in unconditionally.
  - tag[target] <= NULL_TAG only if tag[target] == commit_tag_in. A newer rename survives.
- Issue, at posedge, when dec_issue_in is high, rollback_in is low, and dec_rd_in != 0: tag[rd] <= dec_tag_in.
  - The decoder issues stores and branches with rd = 0, so this needs no opcode.
- Simultaneous issue and commit to the same register: the value is written and the tag takes dec_tag_in (issue wins).
- Rollback, at posedge when rollback_in is high:
  - Every tag becomes NULL_TAG.
  - A same-cycle commit still writes its value.
  - A same-cycle issue is ignored.
- Register x0: never written, tag never set.
- busy_count_out is recomputed each cycle from next-state tags and registered.
  - 0 after rollback or reset.
  - Maximum 31.
- dec_tag_in == NULL_TAG together with issue is illegal input; it is not checked and has no defined effect.
- Tag wrap-around: tags are compared for equality only, so ring reuse of tags is safe. The reorder buffer never reissues a tag that is still in flight.

Decomposition:
- Shared header: XLEN word range, register index range, ROB tag range, NULL_TAG, ZERO_WORD, ZERO_REG_INDEX, REG_COUNT.
- One natural sub-module, rsf_read_port. It holds the combinational per-operand x0, bypass and lookup mux and is instantiated twice (rs1, rs2).
- Storage and the update logic stay in the top module.

Test Plan:
- Reset, then read rs1 = 5, rs2 = 0 -> Qj = 0, Vj = 0, Qk = 0, Vk = 0, busy_count_out = 0.
- Issue rd = 5, tag = 3. Next cycle read rs1 = 5 -> Qj = 3. Then commit target 5, tag 3, data 0xDEADBEEF -> same-cycle read gives Qj = 0, Vj = 0xDEADBEEF. Next cycle value[5] = 0xDEADBEEF, tag cleared, busy_count_out = 0.
- Issue rd = 7 with tag 2, then rd = 7 with tag 4. Commit target 7, tag 2, data 0x11 -> value[7] = 0x11, Q for rs = 7 stays 4, no bypass.
- Same cycle: issue rd = 9 tag 6 and commit target 9 tag 1 (tag[9] was 1) with data 0x55 -> next cycle value[9] = 0x55, tag[9] = 6.
- Tags on x3, x4, x8. Assert rollback_in with commit x3 data 0x77 and issue rd = 10 -> next cycle all Q = 0, value[3] = 0x77, tag[10] = 0, busy_count_out = 0.
- Issue rd = 0 tag 5 and commit target 0 data 0xFF; also pull rst_n low mid-cycle after tags are set -> x0 always reads Q = 0, V = 0. Asynchronous reset clears all tags and values before the next edge.
